// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and sizes for the instruction-memory boot controller
// Purpose: boot FSM state encoding and default instruction-memory geometry.
// Ports: none (package).
package imem_pkg;

  localparam int IMEM_DEPTH = 64;
  localparam int IMEM_AW    = 6;
  localparam int INSTR_W    = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } boot_state_t;

endpackage

// File: rtl/boot_counter.sv
// rtl/boot_counter.sv - word-address counter with sync clear, enable and terminal compare
// Purpose: steps the memory word address during zero-fill and program load.
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   i_clr    in   synchronous clear (wins over i_en)
//   i_en     in   count enable
//   i_tc     in   AW+1-bit terminal value to compare against
//   o_cnt    out  current count
//   o_at_tc  out  count equals i_tc
module boot_counter #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [AW:0]   i_tc,
  output logic [AW-1:0] o_cnt,
  output logic          o_at_tc
);

  logic [AW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + AW'(1);
    end
  end

  // Compared one bit wider so a terminal value of DEPTH-1 or len-1 never aliases.
  assign o_cnt   = r_cnt;
  assign o_at_tc = ({1'b0, r_cnt} == i_tc);

endmodule

// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - boot sequencer and address mux for the core instruction memory
// Purpose: holds the core in reset, zero-fills the memory, loads a streamed program,
//          then releases the core and hands the memory address to the core PC.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, load_len     boot request pulse and program length in words (1..DEPTH)
//   in_valid, in_data   program word stream, in_ready accepts it
//   pc_addr             core fetch word index
//   mem_addr/we/wdata   instruction memory port
//   cpu_reset           core reset, low only in RUN
//   busy, done, err     status: CLEAR/LOAD, RUN, ERR
module imem_boot_ctrl
  import imem_pkg::*;
#(
  parameter int N     = INSTR_W,
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   load_len,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  input  logic [AW-1:0] pc_addr,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [N-1:0]  mem_wdata,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_CLR = (AW+1)'(DEPTH - 1);

  boot_state_t   r_state;
  boot_state_t   w_next;
  logic [AW:0]   r_len;
  logic          r_cpu_reset;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_legal;
  logic          w_beat;
  logic [AW:0]   w_tc;
  logic [AW-1:0] w_cnt;
  logic          w_at_tc;
  logic          w_cnt_clr;
  logic          w_cnt_en;

  assign w_legal = (load_len != '0) && (load_len <= DEPTH_W);

  // A start in LOAD restarts the boot, so it also kills that cycle's beat.
  assign w_beat = (r_state == LOAD) && in_valid && !start;

  assign w_tc      = (r_state == CLEAR) ? LAST_CLR : (r_len - (AW+1)'(1));
  assign w_cnt_en  = (r_state == CLEAR) || w_beat;
  assign w_cnt_clr = start || (w_at_tc && w_cnt_en);

  boot_counter #(.AW(AW)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .i_tc    (w_tc),
    .o_cnt   (w_cnt),
    .o_at_tc (w_at_tc)
  );

  // State register plus registered status decodes of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      if (start && w_legal) begin
        r_len <= load_len;
      end
      r_cpu_reset <= (w_next != RUN);
      r_busy      <= (w_next == CLEAR) || (w_next == LOAD);
      r_done      <= (w_next == RUN);
      r_err       <= (w_next == ERR);
    end
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = w_legal ? CLEAR : ERR;
    end else begin
      case (r_state)
        CLEAR:   if (w_at_tc) w_next = LOAD;
        LOAD:    if (w_beat && w_at_tc) w_next = RUN;
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_addr  = '0;
    case (r_state)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = w_cnt;
      end
      LOAD: begin
        in_ready  = 1'b1;
        mem_we    = w_beat;
        mem_addr  = w_cnt;
        mem_wdata = in_data;
      end
      RUN: begin
        mem_addr = pc_addr;
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

  assign cpu_reset = r_cpu_reset;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - directed-vector bench for imem_boot_ctrl
module tb_imem_boot_ctrl;

  localparam int N     = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   load_len;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic [AW-1:0] pc_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [N-1:0]  mem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          err;

  int n_vec  = 0;
  int n_miss = 0;

  logic [N-1:0] shadow [DEPTH];
  logic         pat [6];

  imem_boot_ctrl #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .load_len  (load_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .pc_addr   (pc_addr),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in, written exactly as the real array would be.
  always @(posedge clk) begin
    if (mem_we) shadow[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic boot_start(input logic [AW:0] len);
    start    = 1'b1;
    load_len = len;
    tick();
    start    = 1'b0;
  endtask

  task automatic run_clear();
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("clr_we", 32'(mem_we), 32'd1);
      check("clr_addr", 32'(mem_addr), 32'(i));
      check("clr_data", mem_wdata, 32'd0);
      check("clr_busy", 32'(busy), 32'd1);
      check("clr_cpu_reset", 32'(cpu_reset), 32'd1);
      tick();
    end
    #1;
    check("load_ready", 32'(in_ready), 32'd1);
    check("load_idle_we", 32'(mem_we), 32'd0);
  endtask

  task automatic beat(input logic [N-1:0] d, input int idx);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    check("beat_we", 32'(mem_we), 32'd1);
    check("beat_addr", 32'(mem_addr), 32'(idx));
    check("beat_data", mem_wdata, d);
    check("beat_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic illegal_run(input logic [AW:0] len);
    int nwe;
    nwe = 0;
    boot_start(len);
    #1;
    check("ill_err", 32'(err), 32'd1);
    check("ill_cpu_reset", 32'(cpu_reset), 32'd1);
    check("ill_done", 32'(done), 32'd0);
    check("ill_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      #1;
      if (mem_we) nwe++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("ill_no_writes", 32'(nwe), 32'd0);
    check("ill_err_hold", 32'(err), 32'd1);
  endtask

  initial begin
    int k;
    reset    = 1'b1;
    start    = 1'b0;
    load_len = '0;
    in_valid = 1'b0;
    in_data  = '0;
    pc_addr  = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = 32'hdeadbeef;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);

    // Basic boot
    boot_start(7'd3);
    run_clear();
    beat(32'h8b1f03c9, 0);
    beat(32'h8b1f03e2, 1);
    beat(32'hb400001f, 2);
    #1;
    check("basic_cpu_reset", 32'(cpu_reset), 32'd0);
    check("basic_done", 32'(done), 32'd1);
    check("basic_busy", 32'(busy), 32'd0);
    check("basic_ready", 32'(in_ready), 32'd0);
    check("mem0", shadow[0], 32'h8b1f03c9);
    check("mem1", shadow[1], 32'h8b1f03e2);
    check("mem2", shadow[2], 32'hb400001f);
    check("mem3", shadow[3], 32'h0);
    check("mem63", shadow[63], 32'h0);
    in_valid = 1'b1;
    #1;
    check("run_ignore_valid", 32'(mem_we), 32'd0);
    in_valid = 1'b0;

    // Backpressure gaps
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    boot_start(7'd3);
    run_clear();
    k = 0;
    for (int j = 0; j < 6; j++) begin
      in_valid = pat[j];
      in_data  = 32'ha0000000 + 32'(j);
      #1;
      check("bp_we", 32'(mem_we), 32'(pat[j]));
      if (pat[j]) check("bp_addr", 32'(mem_addr), 32'(k));
      check("bp_done_early", 32'(done), 32'd0);
      tick();
      if (pat[j]) k++;
    end
    in_valid = 1'b0;
    #1;
    check("bp_done", 32'(done), 32'd1);
    check("bp_cpu_reset", 32'(cpu_reset), 32'd0);
    check("bp_mem0", shadow[0], 32'ha0000000);
    check("bp_mem1", shadow[1], 32'ha0000003);
    check("bp_mem2", shadow[2], 32'ha0000005);

    // Illegal lengths
    illegal_run(7'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("ill_rst_err", 32'(err), 32'd0);
    illegal_run(7'd65);

    // Full memory, started straight from ERR
    boot_start(7'd64);
    run_clear();
    for (int i = 0; i < DEPTH; i++) begin
      beat(32'h10000000 + 32'(i), i);
    end
    #1;
    check("full_done", 32'(done), 32'd1);
    check("full_cpu_reset", 32'(cpu_reset), 32'd0);
    check("full_mem63", shadow[63], 32'h1000003f);
    pc_addr = 6'd5;
    #1;
    check("pc_mux5", 32'(mem_addr), 32'd5);
    pc_addr = 6'd42;
    #1;
    check("pc_mux42", 32'(mem_addr), 32'd42);
    pc_addr = '0;

    // Restart mid-LOAD on the second beat
    boot_start(7'd4);
    run_clear();
    beat(32'hc0de0000, 0);
    start    = 1'b1;
    load_len = 7'd4;
    in_valid = 1'b1;
    in_data  = 32'hc0de0001;
    #1;
    check("rs_we_suppressed", 32'(mem_we), 32'd0);
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rs_mem1_untouched", shadow[1], 32'h0);
    check("rs_mem0_loaded", shadow[0], 32'hc0de0000);
    run_clear();
    check("rs_mem0_cleared", shadow[0], 32'h0);

    // Reset mid-CLEAR at cnt=20
    boot_start(7'd3);
    for (int i = 0; i < 20; i++) tick();
    #1;
    check("mc_addr20", 32'(mem_addr), 32'd20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mc_cpu_reset", 32'(cpu_reset), 32'd1);
    check("mc_busy", 32'(busy), 32'd0);
    check("mc_done", 32'(done), 32'd0);
    check("mc_err", 32'(err), 32'd0);
    check("mc_we", 32'(mem_we), 32'd0);
    check("mc_ready", 32'(in_ready), 32'd0);
    check("mc_addr", 32'(mem_addr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
